nes_shift_reader: RTL and testbench

- Downstream consumer of the NES latch strobe (nesLatch, one-cycle-high pulse from the latch generator).
- On each accepted strobe, reads one controller frame: samples the A bit, then generates 7 nesClk pulses to shift out the other 7 button bits on serial nesData.
- Publishes an 8-bit, active-high button word with a one-cycle valid pulse.
- Sits between the latch generator and the button-consuming logic.

---
 rtl/nes_shift_reader.sv | 70 +++++++
 tb/tb_nes_shift_reader.sv | 115 +++++++++++
 2 files changed

// File: rtl/nes_shift_reader.sv
// nes_shift_reader: reads one NES controller frame per latch strobe and publishes an active-high button word
module nes_shift_reader #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nesLatch,
  input  logic       nesData,
  output logic       nesClk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       overrun
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] PULSE   = 2'd2;
  localparam logic [1:0] SAMPLE  = 2'd3;
  localparam logic [7:0] LAST    = 8'(CLK_DIV - 1);
  logic [1:0] state;
  logic [7:0] phase;
  logic [2:0] bitCount;
  logic [7:0] shiftReg;
  logic [7:0] nextShift;
  logic       phaseEnd;
  assign phaseEnd = phase == LAST;
  always_comb begin
    nextShift = shiftReg;
    nextShift[bitCount] = ~nesData;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state    <= IDLE;
      phase    <= '0;
      bitCount <= '0;
      shiftReg <= '0;
      buttons  <= '0;
      nesClk   <= 1'b0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= nesLatch && state != IDLE;
      phase   <= (state == IDLE || phaseEnd) ? 8'd0 : phase + 8'd1;
      case (state)
        IDLE: if (nesLatch) state <= CAPTURE;
        CAPTURE: if (phaseEnd) begin
          shiftReg <= {7'd0, ~nesData};
          bitCount <= 3'd1;
          nesClk   <= 1'b1;
          state    <= PULSE;
        end
        PULSE: if (phaseEnd) begin
          nesClk <= 1'b0;
          state  <= SAMPLE;
        end
        default: if (phaseEnd) begin
          shiftReg <= nextShift;
          bitCount <= bitCount + 3'd1;
          if (bitCount == 3'd7) begin
            buttons <= nextShift;
            valid   <= 1'b1;
            state   <= IDLE;
          end else begin
            nesClk <= 1'b1;
            state  <= PULSE;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_nes_shift_reader.sv
// tb_nes_shift_reader: scoreboard bench running CLK_DIV=1 and CLK_DIV=3 instances against a frame-level model
module tb_nes_shift_reader;
  typedef struct {
    logic [7:0] word;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  function automatic void chk(string n, int d, int c, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s (CLK_DIV=%0d, cycle %0d): got %0h want %0h", n, d, c, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int D = g ? 3 : 1;
    logic       reset, nesLatch, nesData, nesClk, valid, overrun;
    logic [7:0] buttons;
    logic [7:0] lastBtn = 8'h00;
    int         cyc = 0;
    int         start = -1;
    int         clrAt = 0;
    bit         done = 1'b0;
    bit         expClk[int];
    bit         expOvr[int];
    bit         dataAt[int];
    exp_t       q[$];

    nes_shift_reader #(.CLK_DIV(D)) dut (
      .clk(clk), .reset(reset), .nesLatch(nesLatch), .nesData(nesData),
      .nesClk(nesClk), .buttons(buttons), .valid(valid), .overrun(overrun)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Frame model: bit k is sampled D*(2k+1) cycles after the strobe, nesClk window k covers
    // cycles D*(2k-1)+1 .. 2kD, and the word appears at 15D+1.
    task automatic tick(input bit latch, input bit rstN, input logic [7:0] w);
      int c = cyc;
      reset = rstN;
      nesLatch = latch;
      if (!rstN) begin
        for (int i = c + 1; i <= c + 16 * D + 2; i++) begin
          if (expClk.exists(i)) expClk.delete(i);
          if (expOvr.exists(i)) expOvr.delete(i);
        end
        q.delete();
        start = -1;
        clrAt = c + 1;
      end else if (latch) begin
        if (start >= 0 && c > start && c <= start + 15 * D) expOvr[c + 1] = 1'b1;
        else begin
          start = c;
          for (int k = 0; k < 8; k++) dataAt[c + D * (2 * k + 1)] = ~w[k];
          for (int k = 1; k < 8; k++)
            for (int j = D * (2 * k - 1) + 1; j <= 2 * k * D; j++) expClk[c + j] = 1'b1;
          q.push_back('{w, c + 15 * D + 1});
        end
      end
      nesData = dataAt.exists(c) ? dataAt[c] : 1'($urandom);
      @(posedge clk);
      #1;
    endtask

    initial begin
      int r;
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'h00);
      for (int t = 0; t <= 15 * D + 1; t++)
        tick(t == 0 || t == 5 || t == 15 * D || t == 15 * D + 1, 1'b1,
             t == 15 * D + 1 ? 8'($urandom) : 8'h09);
      for (int t = 0; t < 16 * D + 2; t++) tick(1'b0, 1'b1, 8'h00);
      for (int t = 0; t < 7; t++) tick(t == 0, 1'b1, 8'($urandom));
      tick(1'b0, 1'b0, 8'h00);
      for (int t = 0; t < 2; t++) tick(1'b0, 1'b1, 8'h00);
      tick(1'b1, 1'b1, 8'hFF);
      for (int t = 0; t < 16 * D + 2; t++) tick(1'b0, 1'b1, 8'h00);
      tick(1'b1, 1'b1, 8'h00);
      for (int t = 0; t < 16 * D + 2; t++) tick(1'b0, 1'b1, 8'h00);
      repeat (300) begin
        r = $urandom_range(0, 99);
        tick(r < 12, r != 99, 8'($urandom));
      end
      for (int t = 0; t < 20 * D; t++) tick(1'b0, 1'b1, 8'h00);
      done = 1'b1;
    end

    always @(negedge clk)
      if (cyc >= 1 && !done) begin
        if (cyc == clrAt) lastBtn = 8'h00;
        chk("nesClk", D, cyc, 32'(nesClk), 32'(expClk.exists(cyc)));
        chk("overrun", D, cyc, 32'(overrun), 32'(expOvr.exists(cyc)));
        chk("valid", D, cyc, 32'(valid), 32'(q.size() != 0 && q[0].due == cyc));
        if (valid === 1'b1 && q.size() != 0) begin
          lastBtn = q[0].word;
          void'(q.pop_front());
        end else if (q.size() != 0 && q[0].due <= cyc) void'(q.pop_front());
        chk("buttons", D, cyc, 32'(buttons), 32'(lastBtn));
      end
  end

  initial begin
    for (int i = 0; i < 5000 && !(inst[0].done && inst[1].done); i++) @(posedge clk);
    chk("finished", 0, 0, 32'(inst[0].done && inst[1].done), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
